// File: rtl/tdes_round_ctrl.sv
// Sequencing controller for an iterative Triple-DES core: walks one shared
// Feistel round datapath through NUM_PASSES DES passes of 16 rounds each.
module tdes_round_ctrl #(
    parameter int NUM_PASSES = 3,
    parameter int NUM_ROUNDS = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       mode,
    input  logic       abort,
    output logic       busy,
    output logic       load_block,
    output logic       load_key,
    output logic [1:0] key_sel,
    output logic       dec,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [1:0] pass_idx,
    output logic [1:0] shift_amt,
    output logic       fp_en,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] LAST_PASS  = 2'(NUM_PASSES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t     state_r, state_s;
    logic [3:0] round_r, round_s;
    logic [1:0] pass_r, pass_s;
    logic       mode_r, mode_s;

    logic       busy_s, load_block_s, load_key_s, dec_s, round_en_s, fp_en_s, done_s;
    logic [1:0] key_sel_s, pass_idx_s, shift_amt_s;
    logic [3:0] round_idx_s;

    // EDE order: decrypt walks the keys backwards; single DES always uses key 0.
    function automatic logic [1:0] key_sel_f(input logic [1:0] pass, input logic m);
        logic [1:0] k;
        if (NUM_PASSES == 1) begin
            k = 2'd0;
        end else if (m) begin
            k = 2'd2 - pass;
        end else begin
            k = pass;
        end
        return k;
    endfunction

    // The middle EDE pass always runs opposite to the requested direction.
    function automatic logic dec_f(input logic [1:0] pass, input logic m);
        logic d;
        if (NUM_PASSES == 1) begin
            d = m;
        end else begin
            d = m ^ (pass == 2'd1);
        end
        return d;
    endfunction

    // Decrypt uses the encrypt rotation table mirrored, so round 0 needs no shift.
    function automatic logic [1:0] shift_f(input logic d, input logic [3:0] r);
        logic [1:0] s;
        case (r)
            4'd0:              s = d ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15: s = 2'd1;
            default:           s = 2'd2;
        endcase
        return s;
    endfunction

    // Next-state and counter logic; abort overrides every transition outside IDLE.
    always_comb begin
        state_s = state_r;
        round_s = round_r;
        pass_s  = pass_r;
        mode_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                    mode_s  = mode;
                    round_s = 4'd0;
                    pass_s  = 2'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_ROUND;
                round_s = 4'd0;
            end
            ST_ROUND: begin
                if (round_r == LAST_ROUND) begin
                    state_s = ST_FINAL;
                    round_s = 4'd0;
                end else begin
                    round_s = round_r + 4'd1;
                end
            end
            ST_FINAL: begin
                if (pass_r != LAST_PASS) begin
                    state_s = ST_LOAD;
                    pass_s  = pass_r + 2'd1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                round_s = 4'd0;
                pass_s  = 2'd0;
            end
            default: begin
                state_s = ST_IDLE;
                round_s = 4'd0;
                pass_s  = 2'd0;
            end
        endcase
        if (abort && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
            round_s = 4'd0;
            pass_s  = 2'd0;
        end else begin
            state_s = state_s;
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        busy_s       = 1'b0;
        load_block_s = 1'b0;
        load_key_s   = 1'b0;
        key_sel_s    = 2'd0;
        dec_s        = 1'b0;
        round_en_s   = 1'b0;
        shift_amt_s  = 2'd0;
        fp_en_s      = 1'b0;
        done_s       = 1'b0;
        round_idx_s  = round_s;
        pass_idx_s   = pass_s;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_LOAD: begin
                busy_s       = 1'b1;
                load_key_s   = 1'b1;
                load_block_s = (pass_s == 2'd0);
                key_sel_s    = key_sel_f(pass_s, mode_s);
                dec_s        = dec_f(pass_s, mode_s);
            end
            ST_ROUND: begin
                busy_s      = 1'b1;
                round_en_s  = 1'b1;
                key_sel_s   = key_sel_f(pass_s, mode_s);
                dec_s       = dec_f(pass_s, mode_s);
                shift_amt_s = shift_f(dec_f(pass_s, mode_s), round_s);
            end
            ST_FINAL: begin
                busy_s    = 1'b1;
                fp_en_s   = 1'b1;
                key_sel_s = key_sel_f(pass_s, mode_s);
                dec_s     = dec_f(pass_s, mode_s);
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= ST_IDLE;
            round_r    <= 4'd0;
            pass_r     <= 2'd0;
            mode_r     <= 1'b0;
            busy       <= 1'b0;
            load_block <= 1'b0;
            load_key   <= 1'b0;
            key_sel    <= 2'd0;
            dec        <= 1'b0;
            round_en   <= 1'b0;
            round_idx  <= 4'd0;
            pass_idx   <= 2'd0;
            shift_amt  <= 2'd0;
            fp_en      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            round_r    <= round_s;
            pass_r     <= pass_s;
            mode_r     <= mode_s;
            busy       <= busy_s;
            load_block <= load_block_s;
            load_key   <= load_key_s;
            key_sel    <= key_sel_s;
            dec        <= dec_s;
            round_en   <= round_en_s;
            round_idx  <= round_idx_s;
            pass_idx   <= pass_idx_s;
            shift_amt  <= shift_amt_s;
            fp_en      <= fp_en_s;
            done       <= done_s;
        end
    end

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Scoreboard bench for tdes_round_ctrl: a 3-pass instance and a 1-pass instance,
// expected round controls and done cycles queued by stimulus, checked by a monitor.
module tb_tdes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       n_rst, start, mode, abort;
    logic       busy, load_block, load_key, dec, round_en, fp_en, done;
    logic [1:0] key_sel, pass_idx, shift_amt;
    logic [3:0] round_idx;

    logic       start_b, mode_b, abort_b;
    logic       busy_b, load_block_b, load_key_b, dec_b, round_en_b, fp_en_b, done_b;
    logic [1:0] key_sel_b, pass_idx_b, shift_amt_b;
    logic [3:0] round_idx_b;

    tdes_round_ctrl #(.NUM_PASSES(3), .NUM_ROUNDS(16)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .load_block(load_block), .load_key(load_key), .key_sel(key_sel),
        .dec(dec), .round_en(round_en), .round_idx(round_idx), .pass_idx(pass_idx),
        .shift_amt(shift_amt), .fp_en(fp_en), .done(done)
    );

    tdes_round_ctrl #(.NUM_PASSES(1), .NUM_ROUNDS(16)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .mode(mode_b), .abort(abort_b),
        .busy(busy_b), .load_block(load_block_b), .load_key(load_key_b), .key_sel(key_sel_b),
        .dec(dec_b), .round_en(round_en_b), .round_idx(round_idx_b), .pass_idx(pass_idx_b),
        .shift_amt(shift_amt_b), .fp_en(fp_en_b), .done(done_b)
    );

    logic [16:0] outs_a, outs_b;
    assign outs_a = {busy, load_block, load_key, key_sel, dec, round_en, round_idx,
                     pass_idx, shift_amt, fp_en, done};
    assign outs_b = {busy_b, load_block_b, load_key_b, key_sel_b, dec_b, round_en_b,
                     round_idx_b, pass_idx_b, shift_amt_b, fp_en_b, done_b};

    typedef struct packed {
        logic [1:0] pass;
        logic [3:0] rnd;
        logic [1:0] ksel;
        logic       dec;
        logic [1:0] sh;
    } rec_t;

    rec_t rq[$];
    rec_t rq_b[$];
    int   dq[$];
    int   dq_b[$];
    rec_t mon_e, mon_e_b;
    int   mon_d, mon_d_b;

    // Hand tables: key rotation per round and key/direction per pass.
    logic [1:0] esh [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                             2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0] dsh [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                             2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0] enc_ks [3] = '{2'd0, 2'd1, 2'd2};
    logic       enc_dc [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] dec_ks [3] = '{2'd2, 2'd1, 2'd0};
    logic       dec_dc [3] = '{1'b1, 1'b0, 1'b1};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_extra(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    // Monitor: every DUT round or done is matched against the head of its queue.
    always @(negedge clk) begin
        if (n_rst) begin
            if (round_en) begin
                if (rq.size() == 0) begin
                    report_extra("round_extra_a", {pass_idx, round_idx, key_sel, dec, shift_amt});
                end else begin
                    mon_e = rq.pop_front();
                    check("round_a", {pass_idx, round_idx, key_sel, dec, shift_amt}, mon_e);
                end
            end
            if (fp_en) check("final_quiet_a", {round_en, round_idx, shift_amt}, 32'd0);
            if (done) begin
                if (dq.size() == 0) begin
                    report_extra("done_extra_a", cyc);
                end else begin
                    mon_d = dq.pop_front();
                    check("done_cycle_a", cyc, mon_d);
                end
            end
            if (round_en_b) begin
                if (rq_b.size() == 0) begin
                    report_extra("round_extra_b", {pass_idx_b, round_idx_b, key_sel_b, dec_b, shift_amt_b});
                end else begin
                    mon_e_b = rq_b.pop_front();
                    check("round_b", {pass_idx_b, round_idx_b, key_sel_b, dec_b, shift_amt_b}, mon_e_b);
                end
            end
            if (done_b) begin
                if (dq_b.size() == 0) begin
                    report_extra("done_extra_b", cyc);
                end else begin
                    mon_d_b = dq_b.pop_front();
                    check("done_cycle_b", cyc, mon_d_b);
                end
            end
        end
    end

    // Raise start on dut_a now and queue what the block should produce.
    task automatic launch_a(input logic m, input int last_pass, input int last_round, input bit exp_done);
        rec_t r;
        int   j;
        j     = cyc;
        start = 1'b1;
        mode  = m;
        for (int p = 0; p <= last_pass; p++) begin
            for (int k = 0; k < 16; k++) begin
                if (!((p == last_pass) && (k > last_round))) begin
                    r.pass = 2'(p);
                    r.rnd  = 4'(k);
                    r.ksel = m ? dec_ks[p] : enc_ks[p];
                    r.dec  = m ? dec_dc[p] : enc_dc[p];
                    r.sh   = r.dec ? dsh[k] : esh[k];
                    rq.push_back(r);
                end
            end
        end
        if (exp_done) dq.push_back(j + 55);
    endtask

    task automatic wait_done_a(output int lb, output int lk, output int fp, output bit seen);
        lb = 0; lk = 0; fp = 0; seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            lb += int'(load_block);
            lk += int'(load_key);
            fp += int'(fp_en);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_pos_a(input int p, input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (round_en && (pass_idx == 2'(p)) && (round_idx == 4'(r))) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    int   lb, lk, fp, jb;
    bit   seen, ok;
    rec_t rb;

    initial begin
        n_rst = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        start_b = 1'b0; mode_b = 1'b0; abort_b = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs_a", outs_a, 32'd0);
        check("reset_outs_b", outs_b, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Encrypt block: latency, load strobes, per-pass keys and rotations.
        launch_a(1'b0, 2, 15, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("enc_busy_rise", busy, 32'd1);
        check("enc_load_block", load_block, 32'd1);
        wait_done_a(lb, lk, fp, seen);
        check("enc_done_seen", seen, 32'd1);
        check("enc_load_block_cnt", lb, 32'd1);
        check("enc_load_key_cnt", lk, 32'd3);
        check("enc_fp_cnt", fp, 32'd3);
        @(negedge clk);
        check("enc_busy_fall", busy, 32'd0);
        check("enc_done_one_cycle", done, 32'd0);

        // Decrypt with start held high: ignored while busy, then one IDLE gap.
        @(negedge clk);
        launch_a(1'b1, 2, 15, 1'b1);
        @(negedge clk);
        check("dec_busy_rise", busy, 32'd1);
        wait_done_a(lb, lk, fp, seen);
        check("dec_done_seen", seen, 32'd1);
        check("dec_load_key_cnt", lk, 32'd3);
        @(negedge clk);
        check("b2b_idle_gap", busy, 32'd0);
        launch_a(1'b0, 2, 15, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart", {busy, load_block}, 32'd3);
        wait_done_a(lb, lk, fp, seen);
        check("b2b_done_seen", seen, 32'd1);
        @(negedge clk);
        check("b2b_busy_fall", busy, 32'd0);

        // Start and mode toggled mid-block must not disturb the block in flight.
        @(negedge clk);
        launch_a(1'b0, 2, 15, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_pos_a(1, 5, ok);
        check("restart_reach_p1r5", ok, 32'd1);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done_a(lb, lk, fp, seen);
        check("restart_done_seen", seen, 32'd1);
        @(negedge clk);
        check("restart_no_relaunch", busy, 32'd0);

        // Abort at pass 2 round 10, then abort+start together in IDLE.
        launch_a(1'b0, 2, 10, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_pos_a(2, 10, ok);
        check("abort_reach_p2r10", ok, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outs_zero", outs_a, 32'd0);
        check("abort_rounds_drained", rq.size(), 32'd0);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", outs_a, 32'd0);
        launch_a(1'b0, 2, 15, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_beats_abort", {busy, load_block}, 32'd3);
        wait_done_a(lb, lk, fp, seen);
        check("post_abort_done_seen", seen, 32'd1);
        @(negedge clk);

        // Asynchronous reset between edges in the middle of a round.
        launch_a(1'b1, 0, 7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_pos_a(0, 7, ok);
        check("rst_reach_p0r7", ok, 32'd1);
        #2 n_rst = 1'b0;
        #1 check("rst_async_outs_zero", outs_a, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_stays_idle", outs_a, 32'd0);

        // Single-DES build, decrypt: key 0, dec=1, done in cycle 19.
        jb      = cyc;
        start_b = 1'b1;
        mode_b  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rb.pass = 2'd0;
            rb.rnd  = 4'(k);
            rb.ksel = 2'd0;
            rb.dec  = 1'b1;
            rb.sh   = dsh[k];
            rq_b.push_back(rb);
        end
        dq_b.push_back(jb + 19);
        @(negedge clk);
        start_b = 1'b0;
        mode_b  = 1'b0;
        check("single_load", {busy_b, load_block_b, load_key_b, key_sel_b, dec_b}, 32'h39);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_b) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("single_done_seen", seen, 32'd1);
        @(negedge clk);
        check("single_busy_fall", busy_b, 32'd0);

        check("queue_rounds_a_empty", rq.size(), 32'd0);
        check("queue_done_a_empty", dq.size(), 32'd0);
        check("queue_rounds_b_empty", rq_b.size(), 32'd0);
        check("queue_done_b_empty", dq_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdes_round_ctrl.md
Name: tdes_round_ctrl

Overview:
- Sequencing controller for the iterative Triple-DES core. It drives one shared Feistel round datapath (expansion, key XOR, S-box substitution 48->32, P-permutation) through 3 DES passes of 16 rounds each.
- Per round it generates the pass and round indices, the key-select and the key-schedule shift controls. It also generates the IP/FP strobes and the done handshake.
- It sits between the I2C register front end, which supplies start, mode and abort, and the round datapath and key schedule registers.

Parameters:
- NUM_PASSES, 3, number of DES passes per block. Legal values are 1 (single DES) and 3 (EDE Triple-DES); any other value is illegal.
- NUM_ROUNDS, 16, Feistel rounds per pass. The shift table below is defined for 16 only.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  request to process one block. Sampled only in IDLE.
- mode  input  1  0 = encrypt, 1 = decrypt. Latched when start is accepted.
- abort  input  1  synchronous cancel of the current block.
- busy  output  1  high in every state except IDLE.
- load_block  output  1  datapath captures the input block and applies IP (LOAD state).
- load_key  output  1  key schedule loads the PC-1 of the selected key (LOAD state).
- key_sel  output  2  selects key 0, 1 or 2 for the current pass.
- dec  output  1  current pass runs in decrypt direction; key register rotates right.
- round_en  output  1  datapath executes one Feistel round this cycle.
- round_idx  output  4  current round, 0..15.
- pass_idx  output  2  current pass, 0..NUM_PASSES-1.
- shift_amt  output  2  key rotation amount applied before this round: 0, 1 or 2.
- fp_en  output  1  apply the L/R swap and FP, and write the pass result back (FINAL state).
- done  output  1  one-cycle pulse; the result register is valid.

Behaviour:
- Reset: every output is 0. State is IDLE; round_idx, pass_idx and the latched mode are all 0.
- All outputs are Moore-decoded from registered state and counters. There is no combinational path from any input to any output.
- States:
  - IDLE -> LOAD when start=1. The mode is latched on this transition.
  - LOAD lasts 1 cycle; it asserts load_key, and asserts load_block in pass 0 only -> ROUND.
  - ROUND lasts 16 cycles; round_en=1 and round_idx runs 0..15 -> FINAL after round 15.
  - FINAL lasts 1 cycle; fp_en=1. If pass_idx < NUM_PASSES-1, pass_idx increments -> LOAD. Otherwise -> DONE.
  - DONE lasts 1 cycle; done=1 -> IDLE. pass_idx and round_idx clear to 0.
- Latency: with NUM_PASSES=3, start is accepted at edge k and done is high in the 55th cycle after edge k (3 x 18 cycles, then DONE). With NUM_PASSES=1, done is high in the 19th cycle.
- Pass direction (EDE):
  - Encrypt: pass 0/1/2 uses key_sel 0/1/2 with dec 0/1/0.
  - Decrypt: pass 0/1/2 uses key_sel 2/1/0 with dec 1/0/1.
  - With NUM_PASSES=1: key_sel=0 and dec=mode.
- shift_amt, valid only while round_en=1, otherwise 0:
  - dec=0: 1 at round_idx 0, 1, 8, 15; 2 at all other rounds.
  - dec=1: 0 at round_idx 0; 1 at round_idx 1, 8, 15; 2 at all other rounds.
- Sum check: encrypt shifts total 28 per pass, decrypt shifts total 27 per pass.
- Outside ROUND, round_idx holds 0.
- Boundary conditions:
  - start while busy is ignored, including during DONE.
  - mode changes after acceptance have no effect on the block in flight.
  - abort=1 in any non-IDLE state -> IDLE at the next edge. All outputs return to 0, done is not asserted, counters clear.
  - abort has priority over every state transition. abort together with start in IDLE: start wins, because abort has no effect in IDLE.
  - start held high continuously starts back-to-back blocks: the IDLE cycle between DONE and LOAD is mandatory.
  - n_rst asserted mid-block clears state and outputs immediately, independent of clk. The block is lost.

Test Plan:
- Reset, then a start pulse with mode=0 -> busy rises next cycle; load_block=1 for exactly 1 cycle; done pulses exactly 55 cycles after the accepting edge; busy falls the cycle after done.
- Encrypt run: capture key_sel/dec per pass -> observe 0/0, 1/1, 2/0. Capture shift_amt per round in pass 0 -> 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- Decrypt run: key_sel/dec per pass -> 2/1, 1/0, 0/1. Pass 0 shift_amt -> 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 27).
- Start pulsed again at round 5 of pass 1, and mode toggled at the same time -> no restart and no change to key_sel/dec; done still at cycle 55.
- abort asserted at pass 2, round 10 -> all outputs 0 the next cycle, no done pulse; a new start then completes normally in 55 cycles.
- n_rst dropped mid-ROUND between clock edges -> outputs 0 immediately. NUM_PASSES=1 build with mode=1: key_sel=0, dec=1, done at cycle 19.
